// File: rtl/jpeg_pkg.sv
// Shared JPEG entropy-path constants and the symbol record exchanged with the Huffman stage.
// The same symbol typedef is used by the entropy decoder.
package jpeg_pkg;
  localparam int BLOCK_COEFFS = 64;
  localparam int ZRL_RUN      = 15;
  localparam int MAX_SIZE     = 11;

  typedef struct packed {
    logic [5:0]  run;
    logic [4:0]  size;
    logic [10:0] value;
    logic        dc;
  } entropy_sym_t;

  typedef enum logic {ACCEPT, ZRL} enc_state_t;

  localparam entropy_sym_t ZRL_SYM = '{run: 6'(ZRL_RUN), size: 5'd0, value: 11'd0, dc: 1'b0};
  localparam entropy_sym_t EOB_SYM = '{run: 6'd0, size: 5'd0, value: 11'd0, dc: 1'b0};
endpackage

// File: rtl/jpeg_entropy_encoder_if.sv
// Coefficient-in / symbol-out handshake bundle of the entropy encoder.
// The encoder is the slave; the producer/consumer side is the master.
interface jpeg_entropy_encoder_if;
  logic signed [11:0] value_in;
  logic               valid_in;
  logic               ready_out;
  logic [10:0]        value_out;
  logic [5:0]         run_out;
  logic [4:0]         size_out;
  logic               dc_out;
  logic               valid_out;
  logic               ready_in;

  modport slave (
    input  value_in, valid_in, ready_in,
    output ready_out, value_out, run_out, size_out, dc_out, valid_out
  );

  modport master (
    output value_in, valid_in, ready_in,
    input  ready_out, value_out, run_out, size_out, dc_out, valid_out
  );
endinterface

// File: rtl/magnitude_category.sv
// Combinational JPEG magnitude category: bit length of |value| plus the amplitude bits,
// where negatives are sent as (value - 1) truncated to size bits.
module magnitude_category
  import jpeg_pkg::*;
(
  input  logic signed [11:0] value,
  output logic [4:0]         size,
  output logic [10:0]        amp
);
  logic [10:0] mag;
  logic [10:0] mask;

  always_comb begin
    // Inputs stay within +/-2047, so the magnitude always fits in 11 bits.
    mag  = value[11] ? 11'(-value) : value[10:0];
    size = '0;
    for (int i = 0; i < MAX_SIZE; i++) begin
      if (mag[i]) size = 5'(i + 1);
    end
    mask = 11'((12'd1 << size) - 12'd1);
    amp  = value[11] ? (11'(value - 12'sd1) & mask) : value[10:0];
  end
endmodule

// File: rtl/jpeg_entropy_encoder.sv
// Turns 64-coefficient zig-zag blocks into (run, size, amplitude) symbols with ZRL/EOB,
// using a single output register and a ZRL state that stalls input while runs are split.
module jpeg_entropy_encoder
  import jpeg_pkg::*;
#(
  parameter bit DELTA_ENCODE = 1'b0
) (
  input logic                  clk_in,
  input logic                  rst_in,
  jpeg_entropy_encoder_if.slave bus
);
  enc_state_t         state, state_nxt;
  logic [5:0]         idx, idx_nxt;
  logic [5:0]         zero_run, run_nxt;
  logic signed [11:0] pred, pred_nxt;
  logic [4:0]         lat_size, lat_size_nxt;
  logic [10:0]        lat_amp, lat_amp_nxt;
  entropy_sym_t       sym_p1, sym_nxt;
  logic               vld_p1, vld_nxt;

  logic signed [11:0] mc_in;
  logic [4:0]         mc_size;
  logic [10:0]        mc_amp;
  logic               out_free, accept, last_idx, long_run;

  assign out_free      = !vld_p1 || bus.ready_in;
  assign bus.ready_out = rst_in && (state == ACCEPT) && out_free;
  assign accept        = bus.valid_in && bus.ready_out;
  assign last_idx      = (idx == 6'(BLOCK_COEFFS - 1));
  assign long_run      = (zero_run > 6'(ZRL_RUN));
  assign mc_in         = (DELTA_ENCODE && idx == '0) ? bus.value_in - pred : bus.value_in;

  magnitude_category u_cat (
    .value (mc_in),
    .size  (mc_size),
    .amp   (mc_amp)
  );

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    run_nxt      = zero_run;
    pred_nxt     = pred;
    lat_size_nxt = lat_size;
    lat_amp_nxt  = lat_amp;
    sym_nxt      = sym_p1;
    vld_nxt      = vld_p1 && !bus.ready_in;
    case (state)
      ACCEPT: begin
        if (accept) begin
          idx_nxt = last_idx ? '0 : idx + 6'd1;
          if (idx == '0) begin
            sym_nxt  = '{run: 6'd0, size: mc_size, value: mc_amp, dc: 1'b1};
            vld_nxt  = 1'b1;
            pred_nxt = bus.value_in;
            run_nxt  = '0;
          end else if (bus.value_in == '0) begin
            // A trailing zero closes the block with EOB and drops any pending run.
            if (last_idx) begin
              sym_nxt = EOB_SYM;
              vld_nxt = 1'b1;
              run_nxt = '0;
            end else begin
              run_nxt = zero_run + 6'd1;
            end
          end else if (!long_run) begin
            sym_nxt = '{run: zero_run, size: mc_size, value: mc_amp, dc: 1'b0};
            vld_nxt = 1'b1;
            run_nxt = '0;
          end else begin
            // First ZRL goes out in the accept slot; the coefficient waits in the latch.
            sym_nxt      = ZRL_SYM;
            vld_nxt      = 1'b1;
            run_nxt      = zero_run - 6'(ZRL_RUN + 1);
            lat_size_nxt = mc_size;
            lat_amp_nxt  = mc_amp;
            state_nxt    = ZRL;
          end
        end
      end
      ZRL: begin
        if (out_free) begin
          vld_nxt = 1'b1;
          if (long_run) begin
            sym_nxt = ZRL_SYM;
            run_nxt = zero_run - 6'(ZRL_RUN + 1);
          end else begin
            sym_nxt   = '{run: zero_run, size: lat_size, value: lat_amp, dc: 1'b0};
            run_nxt   = '0;
            state_nxt = ACCEPT;
          end
        end
      end
      default: state_nxt = ACCEPT;
    endcase
  end

  // Output register stage
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= ACCEPT;
      idx      <= '0;
      zero_run <= '0;
      pred     <= '0;
      lat_size <= '0;
      lat_amp  <= '0;
      sym_p1   <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      zero_run <= run_nxt;
      pred     <= pred_nxt;
      lat_size <= lat_size_nxt;
      lat_amp  <= lat_amp_nxt;
      sym_p1   <= sym_nxt;
      vld_p1   <= vld_nxt;
    end
  end

  assign bus.valid_out = vld_p1;
  assign bus.run_out   = sym_p1.run;
  assign bus.size_out  = sym_p1.size;
  assign bus.value_out = sym_p1.value;
  assign bus.dc_out    = sym_p1.dc;
endmodule

// File: tb/tb_jpeg_entropy_encoder.sv
// Bench for jpeg_entropy_encoder: a raw-DC and a delta-DC instance driven in lockstep,
// each scored against a block-level reference model of the symbol stream.
module tb_jpeg_entropy_encoder;
  import jpeg_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   ready_mode = 0;
  int   blk[64];
  int   pred_b = 0;
  entropy_sym_t exp_a[$], exp_b[$], obs_a[$], obs_b[$];

  jpeg_entropy_encoder_if ifa ();
  jpeg_entropy_encoder_if ifb ();

  jpeg_entropy_encoder #(.DELTA_ENCODE(1'b0)) dut_a (.clk_in(clk), .rst_in(rst_n), .bus(ifa));
  jpeg_entropy_encoder #(.DELTA_ENCODE(1'b1)) dut_b (.clk_in(clk), .rst_in(rst_n), .bus(ifb));

  initial forever #5 clk = ~clk;

  function automatic int bitlen(input int x);
    int m = (x < 0) ? -x : x;
    int n = 0;
    while (m != 0) begin
      n++;
      m = m / 2;
    end
    return n;
  endfunction

  function automatic entropy_sym_t mk(input int run, input int v, input bit dc);
    entropy_sym_t s;
    int n = bitlen(v);
    s.run   = 6'(run);
    s.size  = 5'(n);
    s.value = 11'((v >= 0) ? v : v + (1 << n) - 1);
    s.dc    = dc;
    return s;
  endfunction

  task automatic model_block();
    int run = 0;
    exp_a.push_back(mk(0, blk[0], 1'b1));
    exp_b.push_back(mk(0, blk[0] - pred_b, 1'b1));
    pred_b = blk[0];
    for (int k = 1; k < 64; k++) begin
      if (blk[k] == 0) begin
        if (k == 63) begin
          exp_a.push_back(mk(0, 0, 1'b0));
          exp_b.push_back(mk(0, 0, 1'b0));
        end else run++;
      end else begin
        while (run >= 16) begin
          exp_a.push_back(mk(15, 0, 1'b0));
          exp_b.push_back(mk(15, 0, 1'b0));
          run -= 16;
        end
        exp_a.push_back(mk(run, blk[k], 1'b0));
        exp_b.push_back(mk(run, blk[k], 1'b0));
        run = 0;
      end
    end
  endtask

  task automatic tick(output bit acc);
    entropy_sym_t s, e;
    bit rdy;
    @(negedge clk);
    acc = ifa.valid_in && ifa.ready_out;
    if (rst_n && ifa.valid_out && ifa.ready_in) begin
      s = '{run: ifa.run_out, size: ifa.size_out, value: ifa.value_out, dc: ifa.dc_out};
      obs_a.push_back(s);
      total++;
      if (exp_a.size() == 0) begin
        bad++;
        $display("FAIL sym_a_extra: got=%h want=none", s);
      end else begin
        e = exp_a.pop_front();
        if (s !== e) begin
          bad++;
          $display("FAIL sym_a: got=%h want=%h", s, e);
        end
      end
    end
    if (rst_n && ifb.valid_out && ifb.ready_in) begin
      s = '{run: ifb.run_out, size: ifb.size_out, value: ifb.value_out, dc: ifb.dc_out};
      obs_b.push_back(s);
      total++;
      if (exp_b.size() == 0) begin
        bad++;
        $display("FAIL sym_b_extra: got=%h want=none", s);
      end else begin
        e = exp_b.pop_front();
        if (s !== e) begin
          bad++;
          $display("FAIL sym_b: got=%h want=%h", s, e);
        end
      end
    end
    @(posedge clk);
    #1;
    rdy = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
    ifa.ready_in = rdy;
    ifb.ready_in = rdy;
  endtask

  task automatic push_coeff(input int v, output int waits);
    bit acc;
    ifa.value_in = 12'(v);
    ifb.value_in = 12'(v);
    ifa.valid_in = 1'b1;
    ifb.valid_in = 1'b1;
    waits = 0;
    for (int i = 0; i < 300; i++) begin
      tick(acc);
      if (acc) return;
      waits++;
    end
    total++;
    bad++;
    $display("FAIL input_stall: got no accept in %0d cycles, want accept", waits);
  endtask

  task automatic send(input int from, input int to);
    int w;
    for (int k = from; k <= to; k++) push_coeff(blk[k], w);
    ifa.valid_in = 1'b0;
    ifb.valid_in = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    bit acc;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (exp_a.size() == 0 && exp_b.size() == 0) begin
        ok = 1'b1;
        return;
      end
      tick(acc);
    end
  endtask

  task automatic do_reset();
    bit acc;
    rst_n = 1'b0;
    ifa.valid_in = 1'b0;
    ifb.valid_in = 1'b0;
    ready_mode = 0;
    tick(acc);
    tick(acc);
    exp_a.delete(); exp_b.delete(); obs_a.delete(); obs_b.delete();
    pred_b = 0;
    rst_n = 1'b1;
  endtask

  task automatic clear_blk();
    for (int k = 0; k < 64; k++) blk[k] = 0;
  endtask

  task automatic check_drain(input string name);
    bit ok;
    wait_drain(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_drain: got %0d/%0d symbols outstanding, want 0", name, exp_a.size(), exp_b.size());
    end
  endtask

  task automatic test_reset();
    bit acc;
    #1;
    total += 5;
    if (ifa.valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", ifa.valid_out); end
    if (ifa.value_out !== 11'd0) begin bad++; $display("FAIL rst_value: got %h want 0", ifa.value_out); end
    if (ifa.run_out !== 6'd0 || ifa.size_out !== 5'd0) begin bad++; $display("FAIL rst_run_size: got %0d/%0d want 0/0", ifa.run_out, ifa.size_out); end
    if (ifa.dc_out !== 1'b0) begin bad++; $display("FAIL rst_dc: got %b want 0", ifa.dc_out); end
    if (ifa.ready_out !== 1'b0) begin bad++; $display("FAIL rst_ready_low: got %b want 0", ifa.ready_out); end
    @(posedge clk);
    #1;
    tick(acc);
    rst_n = 1'b1;
    #1;
    total += 2;
    if (ifa.ready_out !== 1'b1) begin bad++; $display("FAIL rst_ready_high: got %b want 1", ifa.ready_out); end
    if (ifb.valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid_b: got %b want 0", ifb.valid_out); end
  endtask

  task automatic test_dc_eob();
    do_reset();
    clear_blk();
    blk[0] = 5;
    model_block();
    send(0, 63);
    check_drain("dc_eob");
    total += 3;
    if (obs_a.size() != 2) begin bad++; $display("FAIL dc_eob_count: got %0d want 2", obs_a.size()); end
    if (obs_a[0] !== entropy_sym_t'({6'd0, 5'd3, 11'd5, 1'b1})) begin bad++; $display("FAIL dc_eob_dc: got %h", obs_a[0]); end
    if (obs_a[1] !== entropy_sym_t'(23'd0)) begin bad++; $display("FAIL dc_eob_eob: got %h want 0", obs_a[1]); end
  endtask

  task automatic test_negative_amps();
    do_reset();
    clear_blk();
    blk[0] = -2; blk[1] = -3; blk[2] = -1; blk[3] = 1;
    model_block();
    send(0, 63);
    check_drain("neg");
    total += 4;
    if (obs_a.size() != 5) begin bad++; $display("FAIL neg_count: got %0d want 5", obs_a.size()); end
    if (obs_a[1] !== entropy_sym_t'({6'd0, 5'd2, 11'd0, 1'b0})) begin bad++; $display("FAIL neg_m3: got %h", obs_a[1]); end
    if (obs_a[2] !== entropy_sym_t'({6'd0, 5'd1, 11'd0, 1'b0})) begin bad++; $display("FAIL neg_m1: got %h", obs_a[2]); end
    if (obs_a[3] !== entropy_sym_t'({6'd0, 5'd1, 11'd1, 1'b0})) begin bad++; $display("FAIL neg_p1: got %h", obs_a[3]); end
  endtask

  task automatic test_zrl();
    int w;
    do_reset();
    clear_blk();
    blk[0] = 2; blk[35] = 1; blk[36] = 7;
    model_block();
    send(0, 35);
    push_coeff(blk[36], w);
    send(37, 63);
    check_drain("zrl");
    total += 4;
    if (w != 2) begin bad++; $display("FAIL zrl_stall: got %0d cycles want 2", w); end
    if (obs_a[1] !== ZRL_SYM || obs_a[2] !== ZRL_SYM) begin bad++; $display("FAIL zrl_syms: got %h %h", obs_a[1], obs_a[2]); end
    if (obs_a[3] !== entropy_sym_t'({6'd2, 5'd1, 11'd1, 1'b0})) begin bad++; $display("FAIL zrl_after: got %h", obs_a[3]); end
    if (obs_a.size() != 6) begin bad++; $display("FAIL zrl_count: got %0d want 6", obs_a.size()); end
  endtask

  task automatic test_last_zrl();
    do_reset();
    clear_blk();
    blk[0] = 1; blk[63] = -1024;
    model_block();
    send(0, 63);
    clear_blk();
    blk[0] = 9;
    model_block();
    send(0, 63);
    check_drain("last_zrl");
    total += 3;
    if (obs_a.size() != 7) begin bad++; $display("FAIL last_zrl_count: got %0d want 7", obs_a.size()); end
    if (obs_a[4] !== entropy_sym_t'({6'd14, 5'd11, 11'h3FF, 1'b0})) begin bad++; $display("FAIL last_zrl_sym: got %h", obs_a[4]); end
    if (obs_a[5] !== entropy_sym_t'({6'd0, 5'd4, 11'd9, 1'b1})) begin bad++; $display("FAIL last_zrl_next_dc: got %h", obs_a[5]); end
  endtask

  task automatic test_delta();
    do_reset();
    clear_blk();
    blk[0] = 100;
    model_block();
    send(0, 63);
    blk[0] = 90;
    model_block();
    send(0, 63);
    check_drain("delta");
    total += 3;
    if (obs_b[0] !== entropy_sym_t'({6'd0, 5'd7, 11'd100, 1'b1})) begin bad++; $display("FAIL delta_a: got %h", obs_b[0]); end
    if (obs_b[2] !== entropy_sym_t'({6'd0, 5'd4, 11'd5, 1'b1})) begin bad++; $display("FAIL delta_b: got %h", obs_b[2]); end
    if (obs_a[2] !== entropy_sym_t'({6'd0, 5'd7, 11'd90, 1'b1})) begin bad++; $display("FAIL raw_b: got %h", obs_a[2]); end
  endtask

  task automatic test_back_to_back_random();
    bit sparse;
    do_reset();
    ready_mode = 1;
    for (int b = 0; b < 8; b++) begin
      sparse = 1'(b % 2);
      for (int k = 0; k < 64; k++) begin
        if (k == 0 || (sparse ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0)))
          blk[k] = int'($urandom_range(0, 2047)) - 1024;
        else
          blk[k] = 0;
      end
      model_block();
      send(0, 63);
    end
    check_drain("random");
  endtask

  task automatic test_backpressure();
    bit acc;
    int w;
    do_reset();
    ready_mode = 2;
    tick(acc);
    clear_blk();
    blk[0] = 3; blk[5] = 2;
    model_block();
    push_coeff(blk[0], w);
    ifa.value_in = 12'(blk[1]);
    ifb.value_in = 12'(blk[1]);
    for (int i = 0; i < 5; i++) begin
      tick(acc);
      total += 3;
      if (ifa.valid_out !== 1'b1 || ifa.dc_out !== 1'b1) begin bad++; $display("FAIL bp_valid: got v=%b dc=%b want 1/1", ifa.valid_out, ifa.dc_out); end
      if (ifa.size_out !== 5'd2 || ifa.value_out !== 11'd3) begin bad++; $display("FAIL bp_hold: got size=%0d value=%0d want 2/3", ifa.size_out, ifa.value_out); end
      if (ifa.ready_out !== 1'b0 || acc) begin bad++; $display("FAIL bp_ready: got ready=%b acc=%b want 0/0", ifa.ready_out, acc); end
    end
    ready_mode = 0;
    send(1, 63);
    check_drain("bp");
  endtask

  task automatic test_reset_mid_zrl();
    do_reset();
    clear_blk();
    blk[0] = 4; blk[21] = 5;
    exp_a.push_back(mk(0, 4, 1'b1));
    exp_b.push_back(mk(0, 4, 1'b1));
    send(0, 21);
    total += 2;
    if (ifa.valid_out !== 1'b1 || ifa.run_out !== 6'd15) begin bad++; $display("FAIL midzrl_pending: got v=%b run=%0d want 1/15", ifa.valid_out, ifa.run_out); end
    rst_n = 1'b0;
    #1;
    if (ifa.valid_out !== 1'b0 || ifb.valid_out !== 1'b0) begin bad++; $display("FAIL midzrl_rst: got %b/%b want 0/0", ifa.valid_out, ifb.valid_out); end
    do_reset();
    clear_blk();
    blk[0] = -7;
    model_block();
    send(0, 63);
    check_drain("post_rst");
    total++;
    if (obs_b[0] !== entropy_sym_t'({6'd0, 5'd3, 11'd0, 1'b1})) begin bad++; $display("FAIL post_rst_pred: got %h want %h", obs_b[0], entropy_sym_t'({6'd0, 5'd3, 11'd0, 1'b1})); end
  endtask

  initial begin
    ifa.valid_in = 1'b0; ifb.valid_in = 1'b0;
    ifa.value_in = '0;   ifb.value_in = '0;
    ifa.ready_in = 1'b1; ifb.ready_in = 1'b1;
    test_reset();
    test_dc_eob();
    test_negative_amps();
    test_zrl();
    test_last_zrl();
    test_delta();
    test_back_to_back_random();
    test_backpressure();
    test_reset_mid_zrl();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
